pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
Parametrised pipelined control unit for the RV32I core.
- Decodes the instruction in D.
- Carries control through E, a configurable number of M stages, and W.
- Resolves the full RV32I branch set in E.
- Supports stall and flush, and counts retired instructions.
- Successor to the fixed three-register control pipeline: it adds depth, stall, valid tracking, BLT/BGE signed and unsigned, and a registered JALR select.

Parameters:
MEM_STAGES, 1, number of M pipeline registers between E and W (legal 1..3).
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
op  in  7  opcode in D.
funct3D  in  3  funct3 in D.
funct7b5  in  1  instr[30] in D.
InstrValidD  in  1  D holds a real instruction.
StallE  in  1  hold the E register and inject a bubble into the first M stage.
FlushE  in  1  replace E contents with a bubble.
ZeroE  in  1  ALU result == 0.
SignE  in  1  signed less-than result of the compare.
CarryE  in  1  unsigned less-than result (used only with the feature).
ImmSrcD  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
ALUControlE  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu.
ALUSrcAE  out  1  1 selects PC (auipc).
ALUSrcBE  out  2  00 reg, 01 imm, 10 constant 4.
ResultSrcE0  out  1  ResultSrcE[0] (load-use detection).
PCSrcE  out  1  redirect PC.
PCJalSrcE  out  1  redirect target is the ALU result (jalr).
MemWriteM  out  1  store in the first M stage.
RegWriteM  out  1  RegWrite of the last M stage.
RegWriteW  out  1  RegWrite in W.
ResultSrcW  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm (lui).
InstRetW  out  CNT_W  retired-instruction count.

Behaviour:
- D decode is combinational.
  - Supported opcodes: lw, sw, R, I-ALU, branch, jal, jalr, lui, auipc.
  - Unknown opcode produces all-zero control (bubble); ImmSrcD = 000.
- ALU decode:
  - R-type: funct7b5 distinguishes sub and sra.
  - I-type: funct7b5 distinguishes only srai.
  - Branch decodes to sub.
  - Load, store, jalr and auipc decode to add.
- E register (fields: valid, RegWrite, MemWrite, Jump, Branch, Jalr, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, funct3). Priority per edge:
  1. reset
  2. FlushE → bubble
  3. StallE → hold
  4. load from D
- Bubble: every field zero. When InstrValidD = 0, D is loaded as a bubble.
- FlushE and StallE asserted together: flush wins.
- M stages: shift register of depth MEM_STAGES with fields valid, RegWrite, MemWrite, ResultSrc.
  - MemWrite is meaningful only in stage 1 (MemWriteM = stage1.MemWrite).
  - Stage 1 loads a bubble while StallE = 1.
  - Later stages always advance; there is no M stall.
- W register: valid, RegWrite, ResultSrc; loaded from the last M stage every cycle.
- Branch condition in E, by funct3E:
  - 000: ZeroE.
  - 001: !ZeroE.
  - 100: SignE.
  - 101: !SignE.
  - 110: CarryE, feature only.
  - 111: !CarryE, feature only.
  - 010 and 011: never taken.
- PCSrcE = valid & ((Branch & cond) | Jump); it is combinational from the E register and inputs.
- PCJalSrcE = valid & Jalr, taken from the E register (not from the D opcode).
- InstRetW increments by 1 on each edge where W.valid = 1. It wraps from all-ones to 0.
- Reset (asynchronous, active-low): all pipeline registers clear to bubble and InstRetW = 0. Consequently every registered output is 0. Reset asserted mid-operation discards all in-flight instructions with no partial retirement.
- Latency: D to E 1 cycle; E to W is MEM_STAGES+1 cycles. RegWriteW for an instruction appears MEM_STAGES+2 edges after D, with no stalls.

Optional Feature:
Macro PIPE_CTRL_UNSIGNED_BR_EN.
- Defined: BLTU/BGEU are resolved from CarryE as listed above, and sltu/sltiu decode to 1001.
- Undefined: funct3 110/111 branches are never taken, CarryE is ignored, and sltu/sltiu decode to slt (0101).

Test Plan:
- Reset low for 2 cycles, then high with op = R add → all outputs 0 during reset. With MEM_STAGES = 1, RegWriteW = 1 and ResultSrcW = 00 on the 3rd edge after release; InstRetW = 1 one edge later.
- Branch opcode 1100011, funct3 = 001, ZeroE = 0 in E → PCSrcE = 1. Repeat with ZeroE = 1 → PCSrcE = 0. funct3 = 101 with SignE = 1 → PCSrcE = 0.
- jalr in D followed by add → PCSrcE = 1 and PCJalSrcE = 1 only in the jalr's E cycle; the add's E cycle shows PCJalSrcE = 0.
- sw in D with StallE = 1 held for 2 cycles → ALUControlE stays fixed; MemWriteM = 0 during the stall and = 1 exactly once after release.
- FlushE and StallE asserted together on a lw → E becomes a bubble; ResultSrcE0 = 0; InstRetW does not count it.
- MEM_STAGES = 3, feature on, branch with funct3 = 110 and CarryE = 1 → PCSrcE = 1. An lw issues RegWriteM = 1 three edges after E and ResultSrcW = 01 one edge later. Feature off → same branch gives PCSrcE = 0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// RV32I control pipeline: D decode, E/M*/W control registers, branch resolve, retire counter.
// Build option PIPE_CTRL_UNSIGNED_BR_EN adds BLTU/BGEU resolution and a distinct sltu ALU code.
module pipe_ctrl_unit #(
    parameter int MEM_STAGES = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3D,
    input  logic             funct7b5,
    input  logic             InstrValidD,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             ZeroE,
    input  logic             SignE,
    input  logic             CarryE,
    output logic [2:0]       ImmSrcD,
    output logic [3:0]       ALUControlE,
    output logic             ALUSrcAE,
    output logic [1:0]       ALUSrcBE,
    output logic             ResultSrcE0,
    output logic             PCSrcE,
    output logic             PCJalSrcE,
    output logic             MemWriteM,
    output logic             RegWriteM,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [CNT_W-1:0] InstRetW
);

    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic       memWrite;
        logic       jump;
        logic       branch;
        logic       jalr;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] resultSrc;
        logic [3:0] aluControl;
        logic [2:0] funct3;
    } eCtrl_t;

    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic [1:0] resultSrc;
    } mwCtrl_t;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSlt  = 4'b0101;
    localparam logic [3:0] AluSll  = 4'b0110;
    localparam logic [3:0] AluSrl  = 4'b0111;
    localparam logic [3:0] AluSra  = 4'b1000;
    localparam logic [3:0] AluSltu = 4'b1001;

    localparam logic [1:0] SrcBReg  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAlu = 2'b00;
    localparam logic [1:0] ResMem = 2'b01;
    localparam logic [1:0] ResPc4 = 2'b10;
    localparam logic [1:0] ResImm = 2'b11;

    logic isLoad, isStore, isReg, isImm, isBr;
    logic isJal, isJalr, isLui, isAuipc;

    logic [3:0] aluFunct;
    eCtrl_t     dCtrl;
    eCtrl_t     dLoad;
    eCtrl_t     eReg;
    mwCtrl_t    mIn;
    mwCtrl_t    mReg [MEM_STAGES];
    mwCtrl_t    wReg;
    logic       memWriteM1;
    logic       brTaken;

    assign isLoad  = (op == OpLoad);
    assign isStore = (op == OpStore);
    assign isReg   = (op == OpReg);
    assign isImm   = (op == OpImm);
    assign isBr    = (op == OpBr);
    assign isJal   = (op == OpJal);
    assign isJalr  = (op == OpJalr);
    assign isLui   = (op == OpLui);
    assign isAuipc = (op == OpAuipc);

    // funct7b5 selects sub only for R-type; sra/srai share funct3 101
    always_comb begin
        aluFunct = AluAdd;
        unique case (funct3D)
            3'b000: aluFunct = (isReg && funct7b5) ? AluSub : AluAdd;
            3'b001: aluFunct = AluSll;
            3'b010: aluFunct = AluSlt;
`ifdef PIPE_CTRL_UNSIGNED_BR_EN
            3'b011: aluFunct = AluSltu;
`else
            3'b011: aluFunct = AluSlt;
`endif
            3'b100: aluFunct = AluXor;
            3'b101: aluFunct = funct7b5 ? AluSra : AluSrl;
            3'b110: aluFunct = AluOr;
            3'b111: aluFunct = AluAnd;
        endcase
    end

    always_comb begin
        dCtrl   = '0;
        ImmSrcD = 3'b000;
        unique case (1'b1)
            isLoad: begin
                dCtrl.valid     = 1'b1;
                dCtrl.regWrite  = 1'b1;
                dCtrl.aluSrcB   = SrcBImm;
                dCtrl.resultSrc = ResMem;
            end
            isStore: begin
                dCtrl.valid    = 1'b1;
                dCtrl.memWrite = 1'b1;
                dCtrl.aluSrcB  = SrcBImm;
                ImmSrcD        = 3'b001;
            end
            isReg: begin
                dCtrl.valid      = 1'b1;
                dCtrl.regWrite   = 1'b1;
                dCtrl.aluSrcB    = SrcBReg;
                dCtrl.aluControl = aluFunct;
            end
            isImm: begin
                dCtrl.valid      = 1'b1;
                dCtrl.regWrite   = 1'b1;
                dCtrl.aluSrcB    = SrcBImm;
                dCtrl.aluControl = aluFunct;
            end
            isBr: begin
                dCtrl.valid      = 1'b1;
                dCtrl.branch     = 1'b1;
                dCtrl.aluControl = AluSub;
                ImmSrcD          = 3'b010;
            end
            isJal: begin
                dCtrl.valid     = 1'b1;
                dCtrl.regWrite  = 1'b1;
                dCtrl.jump      = 1'b1;
                dCtrl.aluSrcA   = 1'b1;
                dCtrl.aluSrcB   = SrcBFour;
                dCtrl.resultSrc = ResPc4;
                ImmSrcD         = 3'b011;
            end
            isJalr: begin
                dCtrl.valid     = 1'b1;
                dCtrl.regWrite  = 1'b1;
                dCtrl.jump      = 1'b1;
                dCtrl.jalr      = 1'b1;
                dCtrl.aluSrcB   = SrcBImm;
                dCtrl.resultSrc = ResPc4;
            end
            isLui: begin
                dCtrl.valid     = 1'b1;
                dCtrl.regWrite  = 1'b1;
                dCtrl.aluSrcB   = SrcBImm;
                dCtrl.resultSrc = ResImm;
                ImmSrcD         = 3'b100;
            end
            isAuipc: begin
                dCtrl.valid     = 1'b1;
                dCtrl.regWrite  = 1'b1;
                dCtrl.aluSrcA   = 1'b1;
                dCtrl.aluSrcB   = SrcBImm;
                dCtrl.resultSrc = ResAlu;
                ImmSrcD         = 3'b100;
            end
            default: ;
        endcase
        dCtrl.funct3 = dCtrl.valid ? funct3D : 3'b000;
    end

    assign dLoad = InstrValidD ? dCtrl : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eReg <= '0;
        end else if (FlushE) begin
            eReg <= '0;
        end else if (!StallE) begin
            eReg <= dLoad;
        end
    end

    always_comb begin
        mIn           = '0;
        mIn.valid     = eReg.valid;
        mIn.regWrite  = eReg.regWrite;
        mIn.resultSrc = eReg.resultSrc;
    end

    // a stalled E instruction must not also advance, so M1 takes a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_STAGES; i++) begin
                mReg[i] <= '0;
            end
            memWriteM1 <= 1'b0;
        end else begin
            mReg[0]    <= StallE ? '0 : mIn;
            memWriteM1 <= StallE ? 1'b0 : eReg.memWrite;
            for (int i = 1; i < MEM_STAGES; i++) begin
                mReg[i] <= mReg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wReg     <= '0;
            InstRetW <= '0;
        end else begin
            wReg <= mReg[MEM_STAGES-1];
            if (wReg.valid) begin
                InstRetW <= InstRetW + CNT_W'(1);
            end
        end
    end

    always_comb begin
        brTaken = 1'b0;
        unique case (eReg.funct3)
            3'b000: brTaken = ZeroE;
            3'b001: brTaken = !ZeroE;
            3'b100: brTaken = SignE;
            3'b101: brTaken = !SignE;
`ifdef PIPE_CTRL_UNSIGNED_BR_EN
            3'b110: brTaken = CarryE;
            3'b111: brTaken = !CarryE;
`endif
            default: brTaken = 1'b0;
        endcase
    end

`ifndef PIPE_CTRL_UNSIGNED_BR_EN
    logic unusedCarry;
    assign unusedCarry = CarryE;
`endif

    assign ALUControlE = eReg.aluControl;
    assign ALUSrcAE    = eReg.aluSrcA;
    assign ALUSrcBE    = eReg.aluSrcB;
    assign ResultSrcE0 = eReg.resultSrc[0];
    assign PCSrcE      = eReg.valid & ((eReg.branch & brTaken) | eReg.jump);
    assign PCJalSrcE   = eReg.valid & eReg.jalr;
    assign MemWriteM   = memWriteM1;
    assign RegWriteM   = mReg[MEM_STAGES-1].regWrite;
    assign RegWriteW   = wReg.regWrite;
    assign ResultSrcW  = wReg.resultSrc;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: two depths (1 and 3) driven in lockstep
// against an instruction-record pipeline model.
module tb_pipe_ctrl_unit;

    localparam int DEPA = 1;
    localparam int DEPB = 3;

`ifdef PIPE_CTRL_UNSIGNED_BR_EN
    localparam bit USB = 1'b1;
`else
    localparam bit USB = 1'b0;
`endif

    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    typedef struct packed {
        logic       v;
        logic       rw;
        logic       mw;
        logic       jmp;
        logic       br;
        logic       jr;
        logic       srcA;
        logic [1:0] srcB;
        logic [1:0] res;
        logic [3:0] alu;
        logic [2:0] f3;
    } ctl_t;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3D;
    logic       funct7b5;
    logic       InstrValidD;
    logic       StallE;
    logic       FlushE;
    logic       ZeroE;
    logic       SignE;
    logic       CarryE;

    logic [2:0]  immD  [2];
    logic [3:0]  aluE  [2];
    logic        srcAE [2];
    logic [1:0]  srcBE [2];
    logic        res0E [2];
    logic        pcSrc [2];
    logic        pcJal [2];
    logic        memWM [2];
    logic        regWM [2];
    logic        regWW [2];
    logic [1:0]  resW  [2];
    logic [31:0] retA;
    logic [3:0]  retB;

    ctl_t        eM    [2];
    ctl_t        pM    [2][4];
    logic [31:0] cntM  [2];

    int checks = 0;
    int errors = 0;

    logic [6:0] opTab [9] = '{OP_L, OP_S, OP_R, OP_I, OP_B,
                              OP_JAL, OP_JALR, OP_LUI, OP_AUI};

    pipe_ctrl_unit #(.MEM_STAGES(DEPA), .CNT_W(32)) dutA (
        .clk(clk), .reset(reset), .op(op), .funct3D(funct3D),
        .funct7b5(funct7b5), .InstrValidD(InstrValidD),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE),
        .SignE(SignE), .CarryE(CarryE),
        .ImmSrcD(immD[0]), .ALUControlE(aluE[0]), .ALUSrcAE(srcAE[0]),
        .ALUSrcBE(srcBE[0]), .ResultSrcE0(res0E[0]), .PCSrcE(pcSrc[0]),
        .PCJalSrcE(pcJal[0]), .MemWriteM(memWM[0]), .RegWriteM(regWM[0]),
        .RegWriteW(regWW[0]), .ResultSrcW(resW[0]), .InstRetW(retA)
    );

    pipe_ctrl_unit #(.MEM_STAGES(DEPB), .CNT_W(4)) dutB (
        .clk(clk), .reset(reset), .op(op), .funct3D(funct3D),
        .funct7b5(funct7b5), .InstrValidD(InstrValidD),
        .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE),
        .SignE(SignE), .CarryE(CarryE),
        .ImmSrcD(immD[1]), .ALUControlE(aluE[1]), .ALUSrcAE(srcAE[1]),
        .ALUSrcBE(srcBE[1]), .ResultSrcE0(res0E[1]), .PCSrcE(pcSrc[1]),
        .PCJalSrcE(pcJal[1]), .MemWriteM(memWM[1]), .RegWriteM(regWM[1]),
        .RegWriteW(regWW[1]), .ResultSrcW(resW[1]), .InstRetW(retB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic string tg(input string n, input int i);
        return $sformatf("%s[dep%0d]", n, i == 0 ? DEPA : DEPB);
    endfunction

    function automatic logic [3:0] aluOf(input logic [2:0] f, input logic isR,
                                         input logic b5);
        case (f)
            3'd0:    return (isR && b5) ? 4'd1 : 4'd0;
            3'd1:    return 4'd6;
            3'd2:    return 4'd5;
            3'd3:    return USB ? 4'd9 : 4'd5;
            3'd4:    return 4'd4;
            3'd5:    return b5 ? 4'd8 : 4'd7;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic ctl_t decode(input logic [6:0] o, input logic [2:0] f,
                                    input logic b5);
        ctl_t c = '0;
        c.v  = 1'b1;
        c.f3 = f;
        case (o)
            OP_L:    begin c.rw = 1; c.srcB = 2'd1; c.res = 2'd1; end
            OP_S:    begin c.mw = 1; c.srcB = 2'd1; end
            OP_R:    begin c.rw = 1; c.alu = aluOf(f, 1'b1, b5); end
            OP_I:    begin c.rw = 1; c.srcB = 2'd1; c.alu = aluOf(f, 1'b0, b5); end
            OP_B:    begin c.br = 1; c.alu = 4'd1; end
            OP_JAL:  begin c.rw = 1; c.jmp = 1; c.srcA = 1; c.srcB = 2'd2; c.res = 2'd2; end
            OP_JALR: begin c.rw = 1; c.jmp = 1; c.jr = 1; c.srcB = 2'd1; c.res = 2'd2; end
            OP_LUI:  begin c.rw = 1; c.srcB = 2'd1; c.res = 2'd3; end
            OP_AUI:  begin c.rw = 1; c.srcA = 1; c.srcB = 2'd1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] immOf(input logic [6:0] o);
        case (o)
            OP_S:           return 3'd1;
            OP_B:           return 3'd2;
            OP_JAL:         return 3'd3;
            OP_LUI, OP_AUI: return 3'd4;
            default:        return 3'd0;
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] f, input logic z,
                                   input logic s, input logic c);
        case (f)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return s;
            3'd5:    return !s;
            3'd6:    return USB && c;
            3'd7:    return USB && !c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            eM[i]   = '0;
            cntM[i] = '0;
            for (int k = 0; k < 4; k++) pM[i][k] = '0;
        end
    endtask

    // one clock edge: the instruction record moves E -> M1 .. Mn -> W
    task automatic modelStep();
        ctl_t d;
        int   dp;
        d = InstrValidD ? decode(op, funct3D, funct7b5) : '0;
        if (!reset) begin
            modelReset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                dp = (i == 0) ? DEPA : DEPB;
                if (pM[i][dp].v)
                    cntM[i] = (cntM[i] + 1) & ((i == 0) ? 32'hFFFF_FFFF : 32'hF);
                for (int k = dp; k > 0; k--) pM[i][k] = pM[i][k-1];
                pM[i][0] = StallE ? '0 : eM[i];
                if (FlushE)       eM[i] = '0;
                else if (!StallE) eM[i] = d;
            end
        end
    endtask

    task automatic checkAll();
        ctl_t e;
        int   dp;
        for (int i = 0; i < 2; i++) begin
            dp = (i == 0) ? DEPA : DEPB;
            e  = eM[i];
            check(tg("ImmSrcD", i), 32'(immD[i]), 32'(immOf(op)));
            check(tg("ALUControlE", i), 32'(aluE[i]), 32'(e.alu));
            check(tg("ALUSrcAE", i), 32'(srcAE[i]), 32'(e.srcA));
            check(tg("ALUSrcBE", i), 32'(srcBE[i]), 32'(e.srcB));
            check(tg("ResultSrcE0", i), 32'(res0E[i]), 32'(e.res[0]));
            check(tg("PCSrcE", i), 32'(pcSrc[i]),
                  32'(e.v & ((e.br & taken(e.f3, ZeroE, SignE, CarryE)) | e.jmp)));
            check(tg("PCJalSrcE", i), 32'(pcJal[i]), 32'(e.v & e.jr));
            check(tg("MemWriteM", i), 32'(memWM[i]), 32'(pM[i][0].mw));
            check(tg("RegWriteM", i), 32'(regWM[i]), 32'(pM[i][dp-1].rw));
            check(tg("RegWriteW", i), 32'(regWW[i]), 32'(pM[i][dp].rw));
            check(tg("ResultSrcW", i), 32'(resW[i]), 32'(pM[i][dp].res));
            check(tg("InstRetW", i), (i == 0) ? retA : {28'b0, retB}, cntM[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkAll();
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic b,
                         input logic v, input logic st, input logic fl,
                         input logic z, input logic s, input logic c);
        op = o; funct3D = f; funct7b5 = b; InstrValidD = v;
        StallE = st; FlushE = fl; ZeroE = z; SignE = s; CarryE = c;
    endtask

    task automatic idle();
        drive(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic asyncReset();
        reset = 1'b0;
        #1;
        modelReset();
        checkAll();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        modelReset();
        reset = 1'b0;
        drive(OP_R, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        idle();
        repeat (6) tick();

        drive(OP_B, 3'b001, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_B, 3'b001, 0, 1, 0, 0, 1, 0, 0); tick();
        drive(OP_B, 3'b101, 0, 1, 0, 0, 0, 1, 0); tick();
        drive(OP_B, 3'b000, 0, 1, 0, 0, 1, 0, 0); tick();
        drive(OP_B, 3'b100, 0, 1, 0, 0, 0, 1, 0); tick();
        drive(OP_B, 3'b010, 0, 1, 0, 0, 1, 1, 1); tick();
        drive(OP_B, 3'b110, 0, 1, 0, 0, 0, 0, 1); tick();
        drive(OP_B, 3'b111, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_B, 3'b110, 0, 1, 0, 0, 0, 0, 0); tick();

        drive(OP_JALR, 3'd0, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_R, 3'd0, 0, 1, 0, 0, 0, 0, 0); tick();
        idle(); tick();

        drive(OP_S, 3'b010, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_R, 3'b101, 1, 1, 1, 0, 0, 0, 0); tick(); tick();
        idle(); repeat (5) tick();

        drive(OP_L, 3'b010, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_R, 3'd0, 0, 1, 1, 1, 0, 0, 0); tick();
        idle(); repeat (6) tick();

        drive(OP_L, 3'b010, 0, 1, 0, 0, 0, 0, 0); tick();
        idle(); repeat (6) tick();

        drive(OP_I, 3'b101, 1, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_I, 3'b000, 1, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_I, 3'b011, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_R, 3'b011, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_R, 3'b000, 1, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_JAL, 3'd0, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_LUI, 3'd0, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_AUI, 3'd0, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(7'b1111111, 3'd0, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(OP_R, 3'd0, 0, 1, 0, 0, 0, 0, 0); tick(); tick();
        asyncReset();
        idle(); repeat (6) tick();

        repeat (700) begin
            if ($urandom_range(0, 99) == 0) begin
                asyncReset();
            end
            begin
                int sel;
                sel = $urandom_range(0, 9);
                op = (sel == 9) ? 7'($urandom) : opTab[sel];
            end
            funct3D     = 3'($urandom);
            funct7b5    = 1'($urandom);
            InstrValidD = ($urandom_range(0, 9) != 0);
            StallE      = ($urandom_range(0, 6) == 0);
            FlushE      = ($urandom_range(0, 9) == 0);
            ZeroE       = 1'($urandom);
            SignE       = 1'($urandom);
            CarryE      = 1'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
